// File: rtl/synth_pkg.sv
// Shared constants for the polyphonic tone synth: PS/2 key codes, note
// frequencies and the scan-code to note-index decoder.
package synth_pkg;

  localparam logic [7:0] KEY_DO = 8'h1A;
  localparam logic [7:0] KEY_RE = 8'h22;
  localparam logic [7:0] KEY_MI = 8'h21;
  localparam logic [7:0] KEY_FA = 8'h2A;
  localparam logic [7:0] KEY_SO = 8'h32;
  localparam logic [7:0] KEY_LA = 8'h31;
  localparam logic [7:0] KEY_SI = 8'h3A;

  localparam int unsigned NOTES = 7;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } note_t;

  function automatic note_t note_of(input logic [7:0] code);
    note_t n;
    n.valid = 1'b1;
    n.idx   = '0;
    case (code)
      KEY_DO:  n.idx = 3'd0;
      KEY_RE:  n.idx = 3'd1;
      KEY_MI:  n.idx = 3'd2;
      KEY_FA:  n.idx = 3'd3;
      KEY_SO:  n.idx = 3'd4;
      KEY_LA:  n.idx = 3'd5;
      KEY_SI:  n.idx = 3'd6;
      default: n.valid = 1'b0;
    endcase
    return n;
  endfunction

  // Each branch divides by a literal so the table folds to constants once clk_hz is a parameter.
  function automatic int unsigned note_half(input int unsigned clk_hz, input logic [2:0] idx);
    case (idx)
      3'd0:    return clk_hz / (2 * 523);
      3'd1:    return clk_hz / (2 * 587);
      3'd2:    return clk_hz / (2 * 659);
      3'd3:    return clk_hz / (2 * 698);
      3'd4:    return clk_hz / (2 * 784);
      3'd5:    return clk_hz / (2 * 880);
      default: return clk_hz / (2 * 988);
    endcase
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice: half-period counter with phase toggle on wrap.
module tone_voice #(
  parameter int unsigned DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_restart,
  input  logic [DIV_W-1:0] i_half_period,
  output logic             o_phase
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_phase;

  // >= rather than == so a shorter half-period after an octave change still wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (i_restart) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (!i_enable) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt >= i_half_period - DIV_W'(1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/poly_tone_synth.sv
// Polyphonic PS/2 key synth: voice allocation with round-robin stealing,
// square-wave voices, voice-count mixer and fixed-carrier PWM output.
module poly_tone_synth
  import synth_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned VOICES = 4,
  parameter int unsigned PWM_W  = 8,
  parameter int unsigned DIV_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        key_code,
  input  logic              key_valid,
  input  logic              key_released,
  input  logic [1:0]        octave,
  input  logic              mute,
  output logic              audio_pwm,
  output logic              audio_sd,
  output logic [VOICES-1:0] voice_active
);

  localparam int unsigned PTR_W  = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int unsigned SUM_W  = $clog2(VOICES + 1);
  localparam int unsigned DUTY_W = PWM_W + 1;
  localparam int unsigned SHIFT  = PWM_W - $clog2(VOICES);

  logic [VOICES-1:0] r_busy;
  logic [7:0]        r_code [VOICES];
  logic [2:0]        r_note [VOICES];
  logic [PTR_W-1:0]  r_ptr;
  logic [PWM_W-1:0]  r_pwm_cnt;
  logic [PWM_W-1:0]  r_duty;
  logic              r_pwm;
  logic              r_sd;

  note_t             w_key;
  logic [VOICES-1:0] w_hit;
  logic [VOICES-1:0] w_rel;
  logic [VOICES-1:0] w_alloc;
  logic [VOICES-1:0] w_phase;
  logic              w_press;
  logic              w_have_free;
  logic [PTR_W-1:0]  w_free_idx;
  logic [PTR_W-1:0]  w_victim;
  logic [DIV_W-1:0]  w_half [VOICES];
  logic [SUM_W-1:0]  w_sum;
  logic [DUTY_W-1:0] w_duty_wide;
  logic [PWM_W-1:0]  w_duty;

  // Release wins over a same-cycle press; a held code suppresses re-allocation.
  always_comb begin
    w_key       = note_of(key_code);
    w_hit       = '0;
    w_have_free = 1'b0;
    w_free_idx  = '0;
    for (int unsigned i = 0; i < VOICES; i++) begin
      w_hit[i] = r_busy[i] && (r_code[i] == key_code);
      if (!r_busy[i] && !w_have_free) begin
        w_have_free = 1'b1;
        w_free_idx  = PTR_W'(i);
      end
    end
    w_rel    = key_released ? w_hit : '0;
    w_press  = key_valid && !key_released && w_key.valid && !(|w_hit);
    w_victim = w_have_free ? w_free_idx : r_ptr;
    w_alloc  = '0;
    for (int unsigned i = 0; i < VOICES; i++) begin
      w_alloc[i] = w_press && (w_victim == PTR_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_ptr  <= '0;
      for (int unsigned i = 0; i < VOICES; i++) begin
        r_code[i] <= '0;
        r_note[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < VOICES; i++) begin
        if (w_alloc[i]) begin
          r_busy[i] <= 1'b1;
          r_code[i] <= key_code;
          r_note[i] <= w_key.idx;
        end else if (w_rel[i]) begin
          r_busy[i] <= 1'b0;
        end
      end
      if (w_press && !w_have_free) begin
        r_ptr <= (r_ptr == PTR_W'(VOICES - 1)) ? '0 : r_ptr + PTR_W'(1);
      end
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_voice
    assign w_half[g] = DIV_W'(note_half(CLK_HZ, r_note[g]) >> octave);

    tone_voice #(.DIV_W(DIV_W)) u_voice (
      .clk           (clk),
      .rst           (rst),
      .i_enable      (r_busy[g] && !w_rel[g]),
      .i_restart     (w_alloc[g]),
      .i_half_period (w_half[g]),
      .o_phase       (w_phase[g])
    );
  end

  // Only an all-voices-high sum reaches 2**PWM_W, so saturation is a single-bit test.
  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < VOICES; i++) begin
      w_sum = w_sum + SUM_W'(r_busy[i] & w_phase[i]);
    end
    w_duty_wide = DUTY_W'(w_sum) << SHIFT;
    w_duty      = w_duty_wide[PWM_W] ? '1 : w_duty_wide[PWM_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_cnt <= '0;
      r_duty    <= '0;
      r_pwm     <= 1'b0;
      r_sd      <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      if (&r_pwm_cnt) begin
        r_duty <= w_duty;
      end
      r_pwm <= (r_pwm_cnt < r_duty) && !mute;
      r_sd  <= !mute;
    end
  end

  assign audio_pwm    = r_pwm;
  assign audio_sd     = r_sd;
  assign voice_active = r_busy;

endmodule

// File: tb/tb_poly_tone_synth.sv
// Scoreboard bench for poly_tone_synth: a per-edge reference model of the voice
// table and PWM queues expected outputs; a monitor pops and compares them.
module tb_poly_tone_synth;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned VOICES = 4;
  localparam int unsigned PWM_W  = 4;
  localparam int unsigned DIV_W  = 24;
  localparam int unsigned PWM_MAX = (1 << PWM_W) - 1;

  localparam int unsigned FREQ [7] = '{523, 587, 659, 698, 784, 880, 988};
  localparam logic [7:0]  KEYS [7] = '{8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A};

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        key_code = '0;
  logic              key_valid = 1'b0;
  logic              key_released = 1'b0;
  logic [1:0]        octave = '0;
  logic              mute = 1'b0;
  logic              audio_pwm;
  logic              audio_sd;
  logic [VOICES-1:0] voice_active;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  poly_tone_synth #(
    .CLK_HZ (CLK_HZ),
    .VOICES (VOICES),
    .PWM_W  (PWM_W),
    .DIV_W  (DIV_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_released (key_released),
    .octave       (octave),
    .mute         (mute),
    .audio_pwm    (audio_pwm),
    .audio_sd     (audio_sd),
    .voice_active (voice_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              pwm;
    logic              sd;
    logic [VOICES-1:0] act;
  } exp_t;

  exp_t sb[$];

  // Reference state: a voice's phase is derived from its start edge and half-period.
  bit          m_busy  [VOICES];
  logic [7:0]  m_code  [VOICES];
  int unsigned m_start [VOICES];
  int unsigned m_hp    [VOICES];
  int unsigned m_ptr, m_cyc, m_pwm_cnt, m_duty;
  int          m_sum, m_victim, m_note;
  bit          m_hit;
  exp_t        m_exp;
  exp_t        mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int note_idx(input logic [7:0] c);
    for (int k = 0; k < 7; k++) if (KEYS[k] == c) return k;
    return -1;
  endfunction

  function automatic bit all_idle();
    for (int i = 0; i < int'(VOICES); i++) if (m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < int'(VOICES); i++) begin
      m_busy[i] = 1'b0; m_code[i] = '0; m_start[i] = 0; m_hp[i] = 1;
    end
    m_ptr = 0; m_cyc = 0; m_pwm_cnt = 0; m_duty = 0;
    sb.delete();
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      m_cyc++;
      m_sum = 0;
      for (int i = 0; i < int'(VOICES); i++)
        if (m_busy[i] && (((m_cyc - 1 - m_start[i]) / m_hp[i]) % 2 == 0)) m_sum++;
      m_exp.pwm = (m_pwm_cnt < m_duty) && !mute;
      m_exp.sd  = !mute;
      if (m_pwm_cnt == PWM_MAX) begin
        m_duty = m_sum * (1 << (PWM_W - $clog2(VOICES)));
        if (m_duty > PWM_MAX) m_duty = PWM_MAX;
      end
      m_pwm_cnt = (m_pwm_cnt + 1) % (PWM_MAX + 1);
      m_note = note_idx(key_code);
      if (key_released) begin
        for (int i = 0; i < int'(VOICES); i++)
          if (m_busy[i] && m_code[i] == key_code) m_busy[i] = 1'b0;
      end else if (key_valid && m_note >= 0) begin
        m_hit = 1'b0;
        for (int i = 0; i < int'(VOICES); i++)
          if (m_busy[i] && m_code[i] == key_code) m_hit = 1'b1;
        if (!m_hit) begin
          m_victim = -1;
          for (int i = 0; i < int'(VOICES); i++)
            if (!m_busy[i] && m_victim < 0) m_victim = i;
          if (m_victim < 0) begin
            m_victim = int'(m_ptr);
            m_ptr = (m_ptr + 1) % VOICES;
          end
          m_busy[m_victim]  = 1'b1;
          m_code[m_victim]  = key_code;
          m_start[m_victim] = m_cyc;
          m_hp[m_victim]    = (CLK_HZ / (2 * FREQ[m_note])) >> octave;
        end
      end
      for (int i = 0; i < int'(VOICES); i++) m_exp.act[i] = m_busy[i];
      sb.push_back(m_exp);
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst && sb.size() > 0) begin
      mon_exp = sb.pop_front();
      check("voice_active", 32'(voice_active), 32'(mon_exp.act));
      check("audio_pwm", 32'(audio_pwm), 32'(mon_exp.pwm));
      check("audio_sd", 32'(audio_sd), 32'(mon_exp.sd));
    end
  end

  task automatic send(input logic [7:0] code, input logic v, input logic r);
    @(negedge clk);
    key_code = code; key_valid = v; key_released = r;
    @(negedge clk);
    key_valid = 1'b0; key_released = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_all();
    for (int k = 0; k < 7; k++) send(KEYS[k], 1'b0, 1'b1);
  endtask

  // Reset asserted between clock edges; outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check({tag, "_pwm"}, 32'(audio_pwm), 32'd0);
    check({tag, "_sd"}, 32'(audio_sd), 32'd0);
    check({tag, "_active"}, 32'(voice_active), 32'd0);
    model_clear();
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned op;
    model_clear();
    #1 rst = 1'b1;
    #3;
    check("reset_pwm", 32'(audio_pwm), 32'd0);
    check("reset_sd", 32'(audio_sd), 32'd0);
    check("reset_active", 32'(voice_active), 32'd0);
    idle(2);
    rst = 1'b0;

    send(8'h1A, 1'b1, 1'b0); idle(2000);
    send(8'h22, 1'b1, 1'b0); idle(300);
    send(8'h1A, 1'b0, 1'b1); idle(400);
    send(8'h22, 1'b1, 1'b0); idle(300);
    release_all(); idle(20);

    for (int k = 0; k < 6; k++) begin
      send(KEYS[k], 1'b1, 1'b0); idle(37);
    end
    idle(600);
    release_all();

    send(8'h21, 1'b1, 1'b0); idle(50);
    send(8'h21, 1'b1, 1'b1); idle(50);
    send(8'h55, 1'b1, 1'b0); idle(30);
    send(8'h55, 1'b0, 1'b1); idle(30);

    octave = 2'd2;
    send(8'h3A, 1'b1, 1'b0); idle(700);
    mute = 1'b1; idle(60);
    mute = 1'b0; idle(100);
    async_reset("midnote_rst");
    idle(50);

    for (int n = 0; n < 300; n++) begin
      if (n % 20 == 0) begin
        release_all();
        if (all_idle()) begin
          @(negedge clk);
          octave = 2'($urandom_range(0, 3));
        end
      end
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        if ($urandom_range(0, 9) == 0) send(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        else send(KEYS[$urandom_range(0, 6)], 1'b1, 1'b0);
      end else if (op <= 7) begin
        send(KEYS[$urandom_range(0, 6)], 1'b0, 1'b1);
      end else if (op == 8) begin
        send(KEYS[$urandom_range(0, 6)], 1'b1, 1'b1);
      end else begin
        @(negedge clk);
        mute = ~mute;
      end
      idle($urandom_range(1, 150));
      if (n == 150) async_reset("random_rst");
    end
    @(negedge clk);
    mute = 1'b0;
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
